// File: rtl/xupt_gpio_bank.sv
// xupt_gpio_bank: NPORT bidirectional GPIO ports of WIDTH bits on the CPU register bus.
// Each bit has a direction bit, an output latch and a two-flop input synchroniser.
// Optional feature macro GPIO_IRQ_EN adds the EDGE/IE/IFLAG registers, edge
// detection and the irq output; without it those selects read 0 and irq is 0.
module xupt_gpio_bank #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned NPORT  = 4,
  parameter int unsigned ADDR_W = $clog2(NPORT) + 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cs,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   rvalid,
  inout  wire  [NPORT*WIDTH-1:0] pad,
  output logic                   irq
);

  localparam logic [2:0] SelData  = 3'd0;
  localparam logic [2:0] SelDir   = 3'd1;
  localparam logic [2:0] SelIe    = 3'd2;
  localparam logic [2:0] SelEdge  = 3'd3;
  localparam logic [2:0] SelIflag = 3'd4;

  logic [2:0]       sel;
  logic [31:0]      port_idx;
  logic [NPORT-1:0] wr_port;
  logic [WIDTH-1:0] rd_d;

  logic [WIDTH-1:0] out_q   [NPORT];
  logic [WIDTH-1:0] dir_q   [NPORT];
  logic [WIDTH-1:0] sync1_q [NPORT];
  logic [WIDTH-1:0] sync2_q [NPORT];

  assign sel      = addr[2:0];
  // Zero-extended so indices beyond NPORT never alias onto a real port.
  assign port_idx = 32'(addr >> 3);

  // Per-port write strobe
  always_comb begin
    wr_port = '0;
    for (int p = 0; p < NPORT; p++) begin
      wr_port[p] = cs && we && (port_idx == 32'(p));
    end
  end

  // Output latch and direction registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < NPORT; p++) begin
        out_q[p] <= '0;
        dir_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (wr_port[p] && sel == SelData) out_q[p] <= wdata;
        if (wr_port[p] && sel == SelDir)  dir_q[p] <= wdata;
      end
    end
  end

  // Pad drivers: per-bit tristate straight from the registers
  for (genvar p = 0; p < NPORT; p++) begin : g_port
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      assign pad[p*WIDTH+b] = dir_q[p][b] ? out_q[p][b] : 1'bz;
    end
  end

  // Two-flop input synchroniser
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < NPORT; p++) begin
        sync1_q[p] <= '0;
        sync2_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        sync1_q[p] <= pad[p*WIDTH +: WIDTH];
        sync2_q[p] <= sync1_q[p];
      end
    end
  end

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] ie_q    [NPORT];
  logic [WIDTH-1:0] edge_q  [NPORT];
  logic [WIDTH-1:0] iflag_q [NPORT];
  logic [WIDTH-1:0] prev_q  [NPORT];
  logic [WIDTH-1:0] iflag_d [NPORT];
  logic             irq_q;
  logic             irq_d;

  // Edge detect and flag next state; a new edge beats a same-cycle W1C
  always_comb begin
    irq_d = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      logic [WIDTH-1:0] det;
      logic [WIDTH-1:0] clr;
      det        = (edge_q[p] & sync2_q[p] & ~prev_q[p]) |
                   (~edge_q[p] & ~sync2_q[p] & prev_q[p]);
      clr        = (wr_port[p] && sel == SelIflag) ? wdata : '0;
      iflag_d[p] = (iflag_q[p] & ~clr) | det;
      irq_d      = irq_d | (|(iflag_q[p] & ie_q[p]));
    end
  end

  // Interrupt configuration, flags, edge history and registered irq
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < NPORT; p++) begin
        ie_q[p]    <= '0;
        edge_q[p]  <= '0;
        iflag_q[p] <= '0;
        prev_q[p]  <= '0;
      end
      irq_q <= 1'b0;
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (wr_port[p] && sel == SelIe)   ie_q[p]   <= wdata;
        if (wr_port[p] && sel == SelEdge) edge_q[p] <= wdata;
        iflag_q[p] <= iflag_d[p];
        prev_q[p]  <= sync2_q[p];
      end
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Read mux; unmatched port index or reserved select returns 0
  always_comb begin
    rd_d = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (port_idx == 32'(p)) begin
        case (sel)
          SelData:  rd_d = sync2_q[p];
          SelDir:   rd_d = dir_q[p];
`ifdef GPIO_IRQ_EN
          SelIe:    rd_d = ie_q[p];
          SelEdge:  rd_d = edge_q[p];
          SelIflag: rd_d = iflag_q[p];
`endif
          default:  rd_d = '0;
        endcase
      end
    end
  end

  // Registered read response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= cs && !we;
      if (cs && !we) rdata <= rd_d;
    end
  end

endmodule

// File: tb/tb_xupt_gpio_bank.sv
// Bench for xupt_gpio_bank (WIDTH=4, NPORT=4, ADDR_W widened to 6 so port index 4
// is addressable). Honours GPIO_IRQ_EN the same way the design does.
module tb_xupt_gpio_bank;
  localparam int NP = 4;
  localparam int W  = 4;
  localparam int AW = 6;
  localparam int NB = NP * W;
`ifdef GPIO_IRQ_EN
  localparam bit IrqEn = 1'b1;
`else
  localparam bit IrqEn = 1'b0;
`endif

  typedef struct {
    bit          c;
    bit          w;
    bit [AW-1:0] a;
    bit [W-1:0]  d;
    bit [NB-1:0] ext;
    bit          ev;
    bit [W-1:0]  er;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cs = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [W-1:0]  wdata = '0;
  logic [W-1:0]  rdata;
  logic          rvalid;
  logic          irq;
  wire  [NB-1:0] pad;
  logic [NB-1:0] ext_val = '0;
  logic [NB-1:0] ext_en = '0;

  int n_cmp = 0;
  int n_bad = 0;

  // External drivers stand in for the board pulls on every pin the bank does not drive
  for (genvar i = 0; i < NB; i++) begin : g_ext
    assign pad[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end

  xupt_gpio_bank #(.WIDTH(W), .NPORT(NP), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .cs    (cs),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .rvalid(rvalid),
    .pad   (pad),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Reference model: registers as arrays, pin history as a queue (newest first)
  bit [W-1:0]  m_out [NP];
  bit [W-1:0]  m_dir [NP];
  bit [W-1:0]  m_ie  [NP];
  bit [W-1:0]  m_edg [NP];
  bit [W-1:0]  m_flag[NP];
  bit [NB-1:0] m_lvl [$];
  bit [W-1:0]  m_rdata;
  bit          m_rvalid;
  bit          m_irq;

  function automatic void m_reset();
    for (int p = 0; p < NP; p++) begin
      m_out[p] = '0; m_dir[p] = '0; m_ie[p] = '0; m_edg[p] = '0; m_flag[p] = '0;
    end
    m_lvl = {NB'(0), NB'(0), NB'(0)};
    m_rdata = '0; m_rvalid = 1'b0; m_irq = 1'b0;
  endfunction

  function automatic bit [NB-1:0] m_dirflat();
    bit [NB-1:0] r;
    for (int i = 0; i < NB; i++) r[i] = m_dir[i/W][i%W];
    return r;
  endfunction

  function automatic bit [NB-1:0] m_pad();
    bit [NB-1:0] r;
    for (int i = 0; i < NB; i++) r[i] = m_dir[i/W][i%W] ? m_out[i/W][i%W] : ext_val[i];
    return r;
  endfunction

  function automatic bit [W-1:0] m_read(bit [AW-1:0] a);
    int p;
    int s;
    bit [NB-1:0] lv;
    p = int'(a >> 3);
    s = int'(a & 7);
    lv = m_lvl[1];
    if (p >= NP) return '0;
    case (s)
      0: return lv[p*W +: W];
      1: return m_dir[p];
      2: return IrqEn ? m_ie[p] : '0;
      3: return IrqEn ? m_edg[p] : '0;
      4: return IrqEn ? m_flag[p] : '0;
      default: return '0;
    endcase
  endfunction

  function automatic void m_step(bit c, bit w, bit [AW-1:0] a, bit [W-1:0] d, bit [NB-1:0] lvl);
    int p;
    int s;
    bit any;
    bit now;
    bit old;
    bit hit;
    bit [NB-1:0] l1;
    bit [NB-1:0] l2;
    p = int'(a >> 3);
    s = int'(a & 7);
    any = 1'b0;
    for (int q = 0; q < NP; q++) if ((m_flag[q] & m_ie[q]) != 0) any = 1'b1;
    if (c && !w) m_rdata = m_read(a);
    m_rvalid = c && !w;
    if (IrqEn) begin
      l1 = m_lvl[1];
      l2 = m_lvl[2];
      for (int i = 0; i < NB; i++) begin
        now = l1[i];
        old = l2[i];
        hit = m_edg[i/W][i%W] ? (now && !old) : (!now && old);
        if (c && w && p == i/W && s == 4 && d[i%W]) m_flag[i/W][i%W] = 1'b0;
        if (hit) m_flag[i/W][i%W] = 1'b1;
      end
    end
    if (c && w && p < NP) begin
      case (s)
        0: m_out[p] = d;
        1: m_dir[p] = d;
        2: if (IrqEn) m_ie[p] = d;
        3: if (IrqEn) m_edg[p] = d;
        default: ;
      endcase
    end
    m_lvl.push_front(lvl);
    void'(m_lvl.pop_back());
    m_irq = IrqEn && any;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One bus cycle: drive, clock, advance model, compare all outputs against the model
  task automatic cyc(input bit c, input bit w, input bit [AW-1:0] a, input bit [W-1:0] d);
    bit [NB-1:0] lvl;
    cs = c; we = w; addr = a; wdata = d;
    ext_en = ~m_dirflat();
    #1;
    lvl = m_pad();
    @(posedge clk);
    m_step(c, w, a, d, lvl);
    ext_en = ~m_dirflat();
    #1;
    chk("m_rvalid", 32'(rvalid), 32'(m_rvalid));
    if (m_rvalid) chk("m_rdata", 32'(rdata), 32'(m_rdata));
    chk("m_irq", 32'(irq), 32'(m_irq));
    chk("m_pad", 32'(pad), 32'(m_pad()));
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, '0, '0);
  endtask

  task automatic rd(input bit [AW-1:0] a);
    cyc(1'b1, 1'b0, a, '0);
  endtask

  task automatic wr(input bit [AW-1:0] a, input bit [W-1:0] d);
    cyc(1'b1, 1'b1, a, d);
  endtask

  vec_t tbl[20];

  initial begin
    // Directed DATA/DIR/reserved vectors from reset: {c, w, addr, wdata, ext, rvalid, rdata}
    tbl[0]  = '{0, 0, 6'd0,  4'h0, 16'h0050, 0, 4'h0};
    tbl[1]  = '{0, 0, 6'd0,  4'h0, 16'h0050, 0, 4'h0};
    tbl[2]  = '{1, 0, 6'd8,  4'h0, 16'h0050, 1, 4'h5};
    tbl[3]  = '{0, 0, 6'd0,  4'h0, 16'h0050, 0, 4'h0};
    tbl[4]  = '{1, 1, 6'd1,  4'hF, 16'h0050, 0, 4'h0};
    tbl[5]  = '{1, 1, 6'd0,  4'hA, 16'h0050, 0, 4'h0};
    tbl[6]  = '{0, 0, 6'd0,  4'h0, 16'h0050, 0, 4'h0};
    tbl[7]  = '{0, 0, 6'd0,  4'h0, 16'h0050, 0, 4'h0};
    tbl[8]  = '{1, 0, 6'd0,  4'h0, 16'h0050, 1, 4'hA};
    tbl[9]  = '{1, 0, 6'd1,  4'h0, 16'h0050, 1, 4'hF};
    tbl[10] = '{1, 1, 6'd1,  4'h0, 16'h0053, 0, 4'h0};
    tbl[11] = '{0, 0, 6'd0,  4'h0, 16'h0053, 0, 4'h0};
    tbl[12] = '{0, 0, 6'd0,  4'h0, 16'h0053, 0, 4'h0};
    tbl[13] = '{1, 0, 6'd0,  4'h0, 16'h0053, 1, 4'h3};
    tbl[14] = '{1, 1, 6'd6,  4'hF, 16'h0053, 0, 4'h0};
    tbl[15] = '{1, 0, 6'd6,  4'h0, 16'h0053, 1, 4'h0};
    tbl[16] = '{1, 1, 6'd33, 4'hF, 16'h0053, 0, 4'h0};
    tbl[17] = '{1, 0, 6'd33, 4'h0, 16'h0053, 1, 4'h0};
    tbl[18] = '{1, 0, 6'd1,  4'h0, 16'h0053, 1, 4'h0};
    tbl[19] = '{1, 0, 6'd32, 4'h0, 16'h0053, 1, 4'h0};

    // Reset with port 1 pulled to 0101
    m_reset();
    ext_val = 16'h0050;
    ext_en  = '1;
    #23;
    chk("reset_rdata", 32'(rdata), 32'h0);
    chk("reset_rvalid", 32'(rvalid), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_pad_z", 32'(pad), 32'h0050);
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      ext_val = tbl[i].ext;
      cyc(tbl[i].c, tbl[i].w, tbl[i].a, tbl[i].d);
      chk("vec_rvalid", 32'(rvalid), 32'(tbl[i].ev));
      if (tbl[i].ev) chk("vec_rdata", 32'(rdata), 32'(tbl[i].er));
      if (i == 5) chk("vec_pad_drive", 32'(pad[3:0]), 32'hA);
      if (i == 10) chk("vec_pad_release", 32'(pad[3:0]), 32'h3);
    end

    // Rising edge on pad[8] with EDGE[2]=1, IE[2]=1
    wr(6'd19, 4'h1);
    wr(6'd18, 4'h1);
    idle();
    idle();
    ext_val[8] = 1'b1;
    idle();
    idle();
    idle();
    chk("rise_irq_not_yet", 32'(irq), 32'h0);
    rd(6'd20);
    chk("rise_iflag", 32'(rdata), IrqEn ? 32'h1 : 32'h0);
    chk("rise_irq", 32'(irq), 32'(IrqEn));
    wr(6'd20, 4'h1);
    idle();
    chk("w1c_irq_low", 32'(irq), 32'h0);
    rd(6'd20);
    chk("w1c_iflag", 32'(rdata), 32'h0);

    // W1C coinciding with a new rising edge: the set wins
    ext_val[8] = 1'b0;
    idle();
    ext_val[8] = 1'b1;
    idle();
    idle();
    wr(6'd20, 4'h1);
    rd(6'd20);
    chk("set_wins_iflag", 32'(rdata), IrqEn ? 32'h1 : 32'h0);
    idle();
    chk("set_wins_irq", 32'(irq), 32'(IrqEn));

    // Falling edge on pad[9] with EDGE bit=0, IE bit=0
    wr(6'd20, 4'h1);
    ext_val[9] = 1'b1;
    repeat (4) idle();
    ext_val[9] = 1'b0;
    idle();
    idle();
    idle();
    rd(6'd20);
    chk("fall_iflag", 32'(rdata), IrqEn ? 32'h2 : 32'h0);
    chk("fall_irq_masked", 32'(irq), 32'h0);
    wr(6'd18, 4'h3);
    chk("fall_ie_irq_not_yet", 32'(irq), 32'h0);
    idle();
    chk("fall_ie_irq", 32'(irq), 32'(IrqEn));

    // Mid-operation asynchronous reset releases pads immediately
    wr(6'd1, 4'hF);
    wr(6'd0, 4'hA);
    ext_val[3:0] = 4'h5;
    idle();
    rst = 1'b0;
    m_reset();
    ext_en = '1;
    #1;
    chk("async_pad_release", 32'(pad), 32'(ext_val));
    chk("async_irq", 32'(irq), 32'h0);
    chk("async_rvalid", 32'(rvalid), 32'h0);
    #2;
    rst = 1'b1;

    // High pins at reset release with EDGE=0 raise no flag
    repeat (3) idle();
    rd(6'd12);
    chk("no_spurious_p1", 32'(rdata), 32'h0);
    rd(6'd4);
    chk("no_spurious_p0", 32'(rdata), 32'h0);
    chk("no_spurious_irq", 32'(irq), 32'h0);

    // Randomised traffic against the model
    for (int n = 0; n < 800; n++) begin
      bit c;
      bit w;
      bit [AW-1:0] a;
      bit [W-1:0] d;
      if ($urandom_range(0, 3) == 0) ext_val[$urandom_range(0, NB-1)] ^= 1'b1;
      c = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1) == 1;
      a = AW'($urandom_range(0, 47));
      d = W'($urandom);
      cyc(c, w, a, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xupt_gpio_bank.md
# xupt_gpio_bank

Parametrised general-purpose I/O bank for the xupt CPU family, generalising the fixed 4-bit I/O ports (port7/8/9/a) into NPORT bidirectional ports of WIDTH bits each. Each bit has a direction bit, an output latch and a two-flop input synchroniser, and can raise an edge-triggered interrupt. The bank sits on the CPU's I/O register bus and drives the chip pads directly. External pull-ups and pull-downs define the level of undriven pins.

## Interface
Parameters:
- WIDTH, 4, bits per port.
- NPORT, 4, number of ports (1-16).
- ADDR_W, $clog2(NPORT)+3, register address width.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cs  in  1  register access select.
- we  in  1  1 = write, 0 = read; qualified by cs.
- addr  in  ADDR_W  register address: {port index, sel[2:0]}.
- wdata  in  WIDTH  write data.
- rdata  out  WIDTH  registered read data.
- rvalid  out  1  one-cycle pulse; rdata is valid while it is high.
- pad  inout  NPORT*WIDTH  pins; port p occupies bits [p*WIDTH +: WIDTH].
- irq  out  1  registered interrupt request; level, active high.

## Operation
- Register select (sel) per port:
  - 0 DATA: read returns synchronised pin levels; write loads the output latch.
  - 1 DIR: 1 = output.
  - 2 IE: per-bit interrupt enable.
  - 3 EDGE: 1 = rising edge, 0 = falling edge.
  - 4 IFLAG: read returns pending flags; write-1-to-clear.
  - 5-7: reserved. Reads return 0; writes are ignored.
- A port index >= NPORT reads 0 and ignores writes.
- Pad drive: pad bit = DIR ? OUT : 1'bz.
- DATA read always returns the pin level, never the latch, so an output pin reads back its driven value.
- Input path: sync1 <= pad, sync2 <= sync1, prev <= sync2. An edge is detected from (prev, sync2) according to EDGE.
- IFLAG bit is set on a detected edge regardless of IE. IE gates only irq.
- A set and a W1C on the same bit in the same cycle: the set wins and the flag stays 1.
- Edges are also detected on output-mode pins, because the pad reads back the driven value.
- irq <= |(IFLAG & IE) across all ports, registered.

## Timing
- Reset values: OUT=0, DIR=0 (all inputs, pads at Z), IE=0, EDGE=0, IFLAG=0, sync/prev=0, rdata=0, rvalid=0, irq=0.
- Write: takes effect at the clock edge where cs&we is sampled. Pad drive changes in the same cycle (combinational from the registers).
- Read: cs&!we at edge N gives rdata and rvalid=1 after edge N. rvalid drops after edge N+1 unless a new read is issued. Back-to-back reads are allowed every cycle.
- Pin-to-DATA latency: 2 clocks. Pin edge to IFLAG set: 3 clocks. IFLAG to irq: +1 clock.
- Back-to-back writes then reads to the same register return the new value; there is no hazard.
- Reset asserted mid-operation clears all state immediately and releases the pads to Z asynchronously.
- The flops sampling the first clock edge after reset deassertion must ignore spurious edges. prev and sync reset to 0, so a pin already high with EDGE=0 raises no flag.

## Configuration
- GPIO_IRQ_EN defined: EDGE, IE and IFLAG registers, edge logic and irq are present as specified above.
- GPIO_IRQ_EN undefined: sel 2-4 behave as reserved (read 0, writes ignored), no edge logic is built, and irq is tied to 0. DATA/DIR behaviour and latencies are unchanged.

## Test plan
- Reset with pad bits of port 1 pulled to 4'b0101 (externally): all pads Z; DATA read of port 1 returns 4'h5 two cycles later; rvalid pulses for one cycle; irq=0.
- Write DIR[0]=4'hF, DATA[0]=4'hA: pad[3:0]=4'hA in the same cycle as the write edge. Read DATA[0] returns 4'hA. Set DIR[0]=0: pad returns to Z and reads the external level.
- EDGE[2]=4'h1, IE[2]=4'h1, pad[8] 0->1: IFLAG[2]=4'h1 three clocks later, irq=1 one clock after that. Writing 4'h1 to IFLAG[2] clears it and irq=0 the next cycle.
- With the same setup, W1C issued in the same cycle as a new edge sets the flag: IFLAG stays 4'h1 and irq stays 1.
- Falling edge with EDGE=0, IE=0: IFLAG sets, irq stays 0. Setting IE=1 raises irq one clock later.
- Read or write of sel=6 and of port index NPORT returns 0 with no state change. With GPIO_IRQ_EN undefined, IFLAG reads 0 and irq stays 0 under toggling pins.
